// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection: ALU control decode, MEM/WB forwarding
// and load-use hazard detection with single-bubble insertion.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_result,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              load_use_hazard
);

    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_alu_src;
    logic              load_en;
    logic              take;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    function automatic logic [3:0] decode_alu_ctl(input logic [1:0] alu_op,
                                                  input logic [2:0] funct3,
                                                  input logic       funct7b5);
        logic [3:0] ctl;
        ctl = 4'b1111;
        case (alu_op)
            2'b00: ctl = 4'b0010;
            2'b01: ctl = 4'b0110;
            default: begin
                case (funct3)
                    3'b000: ctl = (alu_op == 2'b10 && funct7b5) ? 4'b0110 : 4'b0010;
                    3'b111: ctl = 4'b0000;
                    3'b110: ctl = 4'b0001;
                    3'b010: ctl = 4'b0111;
                    default: ctl = 4'b1111;
                endcase
            end
        endcase
        return ctl;
    endfunction

    function automatic logic [XLEN-1:0] forward(input logic [REG_AW-1:0] rs,
                                                input logic [XLEN-1:0]   reg_data,
                                                input logic              m_we,
                                                input logic [REG_AW-1:0] m_rd,
                                                input logic [XLEN-1:0]   m_res,
                                                input logic              w_we,
                                                input logic [REG_AW-1:0] w_rd,
                                                input logic [XLEN-1:0]   w_res);
        if (m_we && m_rd != '0 && m_rd == rs)
            return m_res;
        else if (w_we && w_rd != '0 && w_rd == rs)
            return w_res;
        return reg_data;
    endfunction

    assign load_use_hazard = ex_valid && ex_mem_read && ex_rd != '0 &&
                             (ex_rd == id_rs1 || ex_rd == id_rs2);

    // Flush overrides stall; otherwise a non-stalled edge either captures or inserts a bubble.
    assign load_en = flush || !stall;
    assign take    = !flush && id_valid && !load_use_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            alu_ctl       <= 4'b0000;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (load_en) begin
            ex_valid      <= take;
            ex_pc         <= take ? id_pc : '0;
            ex_rs1_data   <= take ? id_rs1_data : '0;
            ex_rs2_data   <= take ? id_rs2_data : '0;
            ex_imm        <= take ? id_imm : '0;
            ex_rs1        <= take ? id_rs1 : '0;
            ex_rs2        <= take ? id_rs2 : '0;
            ex_rd         <= take ? id_rd : '0;
            alu_ctl       <= take ? decode_alu_ctl(id_alu_op, id_funct3, id_funct7b5) : 4'b0000;
            ex_alu_src    <= take && id_alu_src;
            ex_reg_write  <= take && id_reg_write;
            ex_mem_read   <= take && id_mem_read;
            ex_mem_write  <= take && id_mem_write;
            ex_mem_to_reg <= take && id_mem_to_reg;
            ex_branch     <= take && id_branch;
        end
    end

    // EX operand selection (combinational from registered stage state)
    always_comb begin
        fwd_rs1 = forward(ex_rs1, ex_rs1_data, mem_reg_write, mem_rd, mem_result,
                          wb_reg_write, wb_rd, wb_result);
        fwd_rs2 = forward(ex_rs2, ex_rs2_data, mem_reg_write, mem_rd, mem_result,
                          wb_reg_write, wb_rd, wb_result);
        alu_a         = fwd_rs1;
        alu_b         = ex_alu_src ? ex_imm : fwd_rs2;
        ex_store_data = fwd_rs2;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the stage.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, flush, id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [1:0]        id_alu_op;
    logic [2:0]        id_funct3;
    logic              id_funct7b5, id_alu_src;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic              mem_reg_write, wb_reg_write;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic [XLEN-1:0]   mem_result, wb_result;
    logic              ex_valid;
    logic [XLEN-1:0]   alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]        alu_ctl;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic              load_use_hazard;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .load_use_hazard(load_use_hazard)
    );

    // Model of the instruction currently resident in EX; all-zero means bubble.
    typedef struct {
        bit        valid;
        bit [31:0] pc, rs1_data, rs2_data, imm;
        int        rs1, rs2, rd;
        int        ctl;
        bit        alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch;
    } instr_t;

    instr_t m;
    instr_t bubble;

    function automatic int ref_ctl(int op, int f3, bit f7);
        if (op == 0) return 2;
        if (op == 1) return 6;
        if (f3 == 0) return (op == 2 && f7) ? 6 : 2;
        if (f3 == 7) return 0;
        if (f3 == 6) return 1;
        if (f3 == 2) return 7;
        return 15;
    endfunction

    function automatic bit ref_hazard();
        return m.valid && m.mem_read && m.rd != 0 && (m.rd == int'(id_rs1) || m.rd == int'(id_rs2));
    endfunction

    function automatic bit [31:0] ref_fwd(int rs, bit [31:0] reg_data);
        if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == rs) return mem_result;
        if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == rs) return wb_result;
        return reg_data;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit [31:0] f2;
        #1;
        f2 = ref_fwd(m.rs2, m.rs2_data);
        chk({tag, "/ex_valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, "/alu_a"}, alu_a, ref_fwd(m.rs1, m.rs1_data));
        chk({tag, "/alu_b"}, alu_b, m.alu_src ? m.imm : f2);
        chk({tag, "/alu_ctl"}, 32'(alu_ctl), m.ctl);
        chk({tag, "/store"}, ex_store_data, f2);
        chk({tag, "/pc"}, ex_pc, m.pc);
        chk({tag, "/rd"}, 32'(ex_rd), m.rd);
        chk({tag, "/ctrl"}, {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
            {27'd0, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg, m.branch});
        chk({tag, "/hazard"}, 32'(load_use_hazard), 32'(ref_hazard()));
    endtask

    // One clock edge: model decides bubble/hold/capture from the inputs seen at the edge.
    task automatic tick();
        instr_t nxt;
        if (flush) nxt = bubble;
        else if (stall) nxt = m;
        else if (ref_hazard() || !id_valid) nxt = bubble;
        else begin
            nxt.valid = 1; nxt.pc = id_pc; nxt.rs1_data = id_rs1_data; nxt.rs2_data = id_rs2_data;
            nxt.imm = id_imm; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2; nxt.rd = id_rd;
            nxt.ctl = ref_ctl(id_alu_op, id_funct3, id_funct7b5);
            nxt.alu_src = id_alu_src; nxt.reg_write = id_reg_write; nxt.mem_read = id_mem_read;
            nxt.mem_write = id_mem_write; nxt.mem_to_reg = id_mem_to_reg; nxt.branch = id_branch;
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic set_instr(input int rs1, input int rs2, input int rd,
                             input bit [31:0] d1, input bit [31:0] d2, input int op, input int f3,
                             input bit f7);
        id_valid = 1; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        id_rs1_data = d1; id_rs2_data = d2; id_alu_op = 2'(op); id_funct3 = 3'(f3);
        id_funct7b5 = f7; id_pc = $urandom; id_imm = $urandom;
        id_alu_src = 0; id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
        id_mem_to_reg = 0; id_branch = 0;
    endtask

    task automatic clear_fwd();
        mem_reg_write = 0; wb_reg_write = 0; mem_rd = 0; wb_rd = 0;
        mem_result = 0; wb_result = 0;
    endtask

    initial begin
        bubble = '{default: 0};
        m = bubble;
        rst_n = 0; stall = 0; flush = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 0;
        clear_fwd();
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        rst_n = 1;

        // T1: async reset while a valid instruction is resident
        set_instr(1, 2, 3, 32'h1234, 32'h5678, 2, 7, 0);
        id_reg_write = 1; id_branch = 1;
        tick();
        check_all("t1_loaded");
        chk("t1_valid_before", 32'(ex_valid), 1);
        #2 rst_n = 0;
        m = bubble;
        check_all("t1_in_reset");
        chk("t1_ctl_zero", 32'(alu_ctl), 0);
        #2 rst_n = 1;
        id_valid = 0;
        check_all("t1_released");
        chk("t1_a_zero", alu_a, 0);
        chk("t1_b_zero", alu_b, 0);

        // T2: R-type sub, then slt
        set_instr(1, 2, 3, 10, 3, 2, 0, 1);
        tick();
        check_all("t2_sub");
        chk("t2_a", alu_a, 10);
        chk("t2_b", alu_b, 3);
        chk("t2_ctl_sub", 32'(alu_ctl), 32'b0110);
        id_funct3 = 3'b010;
        tick();
        check_all("t2_slt");
        chk("t2_ctl_slt", 32'(alu_ctl), 32'b0111);

        // T3: forwarding priority
        set_instr(5, 6, 8, 32'h11, 32'h22, 0, 0, 0);
        tick();
        mem_reg_write = 1; mem_rd = 5; mem_result = 32'hAA;
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'hBB;
        check_all("t3_mem");
        chk("t3_mem_wins", alu_a, 32'hAA);
        mem_reg_write = 0;
        check_all("t3_wb");
        chk("t3_wb_fwd", alu_a, 32'hBB);
        mem_reg_write = 1; mem_rd = 0; wb_rd = 0;
        check_all("t3_x0");
        chk("t3_reg_data", alu_a, 32'h11);
        clear_fwd();

        // T4: load-use hazard
        set_instr(1, 2, 7, 0, 0, 0, 0, 0);
        id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        set_instr(1, 7, 9, 1, 2, 2, 0, 0);
        check_all("t4_detect");
        chk("t4_hazard", 32'(load_use_hazard), 1);
        tick();
        check_all("t4_bubble");
        chk("t4_valid0", 32'(ex_valid), 0);
        chk("t4_mem_read0", 32'(ex_mem_read), 0);
        set_instr(1, 0, 0, 0, 0, 0, 0, 0);
        id_mem_read = 1;
        tick();
        check_all("t4_rd0");
        chk("t4_no_hazard", 32'(load_use_hazard), 0);

        // T5: stall, stall+flush, invalid ID
        set_instr(3, 4, 5, 32'h33, 32'h44, 2, 6, 0);
        id_pc = 32'h100;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(i + 1, 2, 6, $urandom, $urandom, 2, 7, 0);
            tick();
            check_all("t5_stall");
            chk("t5_pc_frozen", ex_pc, 32'h100);
        end
        flush = 1;
        tick();
        check_all("t5_flush");
        chk("t5_flush_valid0", 32'(ex_valid), 0);
        stall = 0; flush = 0;
        set_instr(3, 4, 5, 1, 2, 0, 0, 0);
        tick();
        id_valid = 0;
        tick();
        check_all("t5_invalid");
        chk("t5_invalid_valid0", 32'(ex_valid), 0);

        // T6: I-type addi with negative immediate
        set_instr(1, 2, 3, 5, 6, 3, 0, 1);
        id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
        tick();
        check_all("t6_addi");
        chk("t6_b_imm", alu_b, 32'hFFFF_FFFC);
        chk("t6_ctl_add", 32'(alu_ctl), 32'b0010);

        // Randomized traffic with small register indices to provoke forwarding and hazards
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            id_valid = ($urandom_range(0, 5) != 0);
            id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_alu_op = 2'($urandom); id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
            id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
            id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
            id_mem_to_reg = 1'($urandom); id_branch = 1'($urandom);
            mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
            wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
            check_all("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
